// File: rtl/ternary_vector_mac_pkg.sv
// Shared trit encodings, kernel codes and FSM states for the ternary vector MAC.
package ternary_pkg;

  localparam logic [1:0] TRIT_ZERO = 2'b00;
  localparam logic [1:0] TRIT_POS  = 2'b01;
  localparam logic [1:0] TRIT_NEG  = 2'b10;
  localparam logic [1:0] TRIT_BAD  = 2'b11;

  localparam logic [2:0] KERNEL_DOT = 3'h1;
  localparam logic [2:0] KERNEL_MUL = 3'h3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_OUT
  } state_t;

  function automatic logic is_kernel(input logic [2:0] op);
    return (op == KERNEL_DOT) || (op == KERNEL_MUL);
  endfunction

endpackage

// File: rtl/ternary_vector_mac_if.sv
// Beat input stream and result output stream of the ternary vector MAC.
interface ternary_vector_mac_if #(
  parameter int LANES = 8,
  parameter int ACC_W = 32
);
  logic                    in_valid;
  logic                    in_ready;
  logic [2*LANES-1:0]      weights;
  logic [2*LANES-1:0]      trits;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] result;

  modport master (
    output in_valid, weights, trits, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, weights, trits, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/ternary_vector_mac_lane_sum.sv
// Combinational reduction of LANES ternary products to a signed beat sum.
module ternary_lane_sum
  import ternary_pkg::*;
#(
  parameter int LANES = 8,
  parameter int SUM_W = $clog2(LANES + 1) + 1
) (
  input  logic [2*LANES-1:0]      weights,
  input  logic [2*LANES-1:0]      trits,
  output logic signed [SUM_W-1:0] sum,
  output logic                    bad
);

  localparam logic signed [SUM_W-1:0] ONE = SUM_W'(1);

  always_comb begin
    sum = '0;
    bad = 1'b0;
    for (int unsigned i = 0; i < LANES; i++) begin
      // Illegal operands flag the beat but add nothing to the sum.
      if (weights[2*i +: 2] == TRIT_BAD || trits[2*i +: 2] == TRIT_BAD) begin
        bad = 1'b1;
      end else if (weights[2*i +: 2] != TRIT_ZERO && trits[2*i +: 2] != TRIT_ZERO) begin
        if (weights[2*i +: 2] == trits[2*i +: 2]) sum = sum + ONE;
        else                                       sum = sum - ONE;
      end
    end
  end

endmodule

// File: rtl/ternary_vector_mac.sv
// LANES-wide ternary dot-product / per-beat multiply engine with valid/ready streams.
// Optional saturating accumulation: define TERNARY_VMAC_SAT_EN.
module ternary_vector_mac
  import ternary_pkg::*;
#(
  parameter int LANES = 8,
  parameter int ACC_W = 32,
  parameter int LEN_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2:0]           op_mode,
  input  logic [LEN_W-1:0]     len,
  ternary_vector_mac_if.slave  bus,
  output logic                 busy,
  output logic                 err_encoding
);

  localparam int SUM_W = $clog2(LANES + 1) + 1;

  state_t                  state;
  logic                    mul_mode;
  logic [LEN_W-1:0]        len_q;
  logic [LEN_W-1:0]        count;
  logic                    s1_valid;
  logic signed [SUM_W-1:0] s1_sum;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [SUM_W-1:0] beat_sum;
  logic                    beat_bad;
  logic                    accept;
  logic [ACC_W:0]          wide;

  ternary_lane_sum #(
    .LANES (LANES),
    .SUM_W (SUM_W)
  ) u_lane_sum (
    .weights (bus.weights),
    .trits   (bus.trits),
    .sum     (beat_sum),
    .bad     (beat_bad)
  );

  assign accept = bus.in_valid && bus.in_ready;

  // Stage-2 value; one extra bit exposes signed overflow for the saturating build.
  always_comb begin
    wide = {acc[ACC_W-1], acc} + {{(ACC_W + 1 - SUM_W){s1_sum[SUM_W-1]}}, s1_sum};
`ifdef TERNARY_VMAC_SAT_EN
    if (wide[ACC_W] != wide[ACC_W-1])
      acc_next = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      acc_next = wide[ACC_W-1:0];
`else
    acc_next = wide[ACC_W-1:0];
`endif
    if (mul_mode) acc_next = ACC_W'(s1_sum);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      mul_mode     <= 1'b0;
      len_q        <= '0;
      count        <= '0;
      s1_valid     <= 1'b0;
      s1_sum       <= '0;
      acc          <= '0;
      busy         <= 1'b0;
      err_encoding <= 1'b0;
      bus.in_ready <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.result   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_sum <= beat_sum;
        count  <= count + 1'b1;
        if (beat_bad) err_encoding <= 1'b1;
      end
      if (s1_valid) acc <= acc_next;

      case (state)
        ST_IDLE: begin
          if (start && is_kernel(op_mode)) begin
            mul_mode     <= (op_mode == KERNEL_MUL);
            len_q        <= len;
            acc          <= '0;
            count        <= '0;
            err_encoding <= 1'b0;
            busy         <= 1'b1;
            if (len == '0) begin
              state         <= ST_OUT;
              bus.out_valid <= 1'b1;
              bus.result    <= '0;
            end else begin
              state        <= ST_RUN;
              bus.in_ready <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (accept && (mul_mode || (count + 1'b1) == len_q)) begin
            bus.in_ready <= 1'b0;
            state        <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // The last accepted beat reaches stage 2 here; publish its accumulation directly.
          if (s1_valid) begin
            bus.result    <= acc_next;
            bus.out_valid <= 1'b1;
            state         <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            if (mul_mode && count != len_q) begin
              state        <= ST_RUN;
              bus.in_ready <= 1'b1;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ternary_vector_mac.sv
// Directed bench for ternary_vector_mac: a 32-bit instance plus an 8-bit one for accumulator overflow.
module tb_ternary_vector_mac;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op_mode;
  logic [15:0] len;
  logic        busy, err;
  logic        busy8, err8;

  int checks   = 0;
  int failures = 0;
  int n;

  ternary_vector_mac_if #(.LANES(8), .ACC_W(32)) bus ();
  ternary_vector_mac_if #(.LANES(8), .ACC_W(8))  bus8 ();

  assign bus8.in_valid  = bus.in_valid;
  assign bus8.weights   = bus.weights;
  assign bus8.trits     = bus.trits;
  assign bus8.out_ready = bus.out_ready;

  ternary_vector_mac #(.LANES(8), .ACC_W(32), .LEN_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .op_mode      (op_mode),
    .len          (len),
    .bus          (bus),
    .busy         (busy),
    .err_encoding (err)
  );

  ternary_vector_mac #(.LANES(8), .ACC_W(8), .LEN_W(16)) dut8 (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .op_mode      (op_mode),
    .len          (len),
    .bus          (bus8),
    .busy         (busy8),
    .err_encoding (err8)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [2:0] op, input logic [15:0] l);
    start   = 1'b1;
    op_mode = op;
    len     = l;
    tick();
    start = 1'b0;
  endtask

  // Present a beat and hold it until the DUT takes it; in_valid stays high afterwards.
  task automatic beat(input logic [15:0] w, input logic [15:0] t);
    bus.in_valid = 1'b1;
    bus.weights  = w;
    bus.trits    = t;
    for (int i = 0; i < 20 && !bus.in_ready; i++) tick();
    if (!bus.in_ready) check("in_ready_wait", {31'b0, bus.in_ready}, 32'd1);
    tick();
  endtask

  task automatic wait_out(output int cycles);
    cycles = 0;
    while (!bus.out_valid && cycles < 20) begin
      tick();
      cycles++;
    end
    if (!bus.out_valid) check("out_valid_wait", {31'b0, bus.out_valid}, 32'd1);
  endtask

  task automatic take_result();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    start         = 1'b0;
    op_mode       = 3'h0;
    len           = '0;
    bus.in_valid  = 1'b0;
    bus.weights   = '0;
    bus.trits     = '0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    check("rst_busy",      {31'b0, busy},          32'd0);
    check("rst_in_ready",  {31'b0, bus.in_ready},  32'd0);
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_result",    bus.result,             32'd0);
    check("rst_err",       {31'b0, err},           32'd0);
    reset = 1'b0;
    tick();

    // Unsupported kernel code is ignored
    start_job(3'h2, 16'd3);
    check("badop_busy",     {31'b0, busy},         32'd0);
    check("badop_in_ready", {31'b0, bus.in_ready}, 32'd0);

    // 1: DOT len=3, all lanes +1*+1
    start_job(3'h1, 16'd3);
    check("t1_busy",     {31'b0, busy},         32'd1);
    check("t1_in_ready", {31'b0, bus.in_ready}, 32'd1);
    repeat (3) beat(16'h5555, 16'h5555);
    bus.in_valid = 1'b0;
    wait_out(n);
    check("t1_latency", n,          32'd1);
    check("t1_result",  bus.result, 32'd24);
    take_result();
    check("t1_out_clr", {31'b0, bus.out_valid}, 32'd0);
    check("t1_idle",    {31'b0, busy},          32'd0);

    // 2: DOT len=2, -8 then 0
    start_job(3'h1, 16'd2);
    beat(16'h5555, 16'hAAAA);
    beat(16'h0000, 16'h5555);
    bus.in_valid = 1'b0;
    wait_out(n);
    check("t2_result", bus.result, 32'hFFFF_FFF8);
    take_result();

    // 3: MUL len=2, sums +3 then -5 with backpressure on the first result
    start_job(3'h3, 16'd2);
    beat(16'h0015, 16'h0015);
    bus.weights = 16'h0155;
    bus.trits   = 16'h02AA;
    wait_out(n);
    check("t3_latency1", n,          32'd1);
    check("t3_result1",  bus.result, 32'd3);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t3_hold_ready",  {31'b0, bus.in_ready},  32'd0);
      check("t3_hold_valid",  {31'b0, bus.out_valid}, 32'd1);
      check("t3_hold_result", bus.result,             32'd3);
    end
    take_result();
    check("t3_rerun_ready", {31'b0, bus.in_ready}, 32'd1);
    beat(16'h0155, 16'h02AA);
    bus.in_valid = 1'b0;
    wait_out(n);
    check("t3_latency2", n,          32'd1);
    check("t3_result2",  bus.result, 32'hFFFF_FFFB);
    take_result();
    check("t3_idle", {31'b0, busy}, 32'd0);

    // 4: illegal weight on lane 0
    start_job(3'h1, 16'd1);
    beat(16'h5557, 16'h5555);
    bus.in_valid = 1'b0;
    wait_out(n);
    check("t4_result", bus.result,   32'd7);
    check("t4_err",    {31'b0, err}, 32'd1);
    take_result();
    check("t4_err_sticky", {31'b0, err}, 32'd1);
    start_job(3'h1, 16'd1);
    check("t4_err_clear", {31'b0, err}, 32'd0);
    beat(16'h0000, 16'h0000);
    bus.in_valid = 1'b0;
    wait_out(n);
    check("t4_zero_result", bus.result, 32'd0);
    take_result();

    // 5: 20 beats of +8 overflow the 8-bit accumulator
    start_job(3'h1, 16'd20);
    repeat (20) beat(16'h5555, 16'h5555);
    bus.in_valid = 1'b0;
    wait_out(n);
    check("t5_result32", bus.result, 32'd160);
`ifdef TERNARY_VMAC_SAT_EN
    check("t5_result8", {24'b0, bus8.result}, 32'h0000_007F);
`else
    check("t5_result8", {24'b0, bus8.result}, 32'h0000_00A0);
`endif
    take_result();

    // 6: reset mid-RUN, then a zero-length job
    start_job(3'h1, 16'd5);
    beat(16'h5557, 16'h5555);
    beat(16'h5555, 16'h5555);
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    tick();
    check("t6_busy",      {31'b0, busy},          32'd0);
    check("t6_in_ready",  {31'b0, bus.in_ready},  32'd0);
    check("t6_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("t6_result",    bus.result,             32'd0);
    check("t6_err",       {31'b0, err},           32'd0);
    reset = 1'b0;
    tick();
    start_job(3'h1, 16'd0);
    check("t6_len0_valid",  {31'b0, bus.out_valid}, 32'd1);
    check("t6_len0_result", bus.result,             32'd0);
    check("t6_len0_busy",   {31'b0, busy},          32'd1);
    take_result();
    check("t6_len0_idle", {31'b0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
